// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush scheduler for the pc_reg -> if_id -> id_ex -> ex core.
// state | meaning: RUN (0) free-running | EX_HOLD (1) ex multi-cycle hold | EXT_HOLD (2) external stall
module pipe_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        load_use_i,
    input  logic        ext_hold_i,
    input  logic        cnt_clr_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic [1:0]  state_o,
    output logic        timeout_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] EX_HOLD  = 2'd1;
    localparam logic [1:0] EXT_HOLD = 2'd2;

    // Down-counter: loaded on EX_HOLD entry (one hold cycle already spent), terminal at zero.
    localparam logic [TO_W-1:0] TC_LOAD = TO_W'(TIMEOUT_CYCLES - 2);

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] left_q, left_d;
    logic            to_set, run_rules;
    logic            jmp, h_pc, h_ifid, h_idex, f_ifid, f_idex;

    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        to_set    = 1'b0;
        run_rules = 1'b0;
        jmp       = 1'b0;
        h_pc      = 1'b0;
        h_ifid    = 1'b0;
        h_idex    = 1'b0;
        f_ifid    = 1'b0;
        f_idex    = 1'b0;
        case (state_q)
            EX_HOLD: begin
                if (ext_hold_i) begin
                    {h_pc, h_ifid, h_idex} = 3'b111;
                    state_d = EXT_HOLD;
                    left_d  = '0;
                end else if (hold_flag_i) begin
                    if (left_q != '0) begin
                        {h_pc, h_ifid, h_idex} = 3'b111;
                        left_d = left_q - TO_W'(1);
                    end else begin
                        f_idex  = 1'b1;
                        to_set  = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    run_rules = 1'b1;
                end
            end
            EXT_HOLD: begin
                if (ext_hold_i) begin
                    {h_pc, h_ifid, h_idex} = 3'b111;
                end else begin
                    run_rules = 1'b1;
                end
            end
            default: run_rules = 1'b1;
        endcase

        // Release paths reuse the RUN priority in the same cycle.
        if (run_rules) begin
            state_d = RUN;
            left_d  = '0;
            if (ext_hold_i) begin
                {h_pc, h_ifid, h_idex} = 3'b111;
                state_d = EXT_HOLD;
            end else if (jump_en_i) begin
                jmp    = 1'b1;
                f_ifid = 1'b1;
                f_idex = 1'b1;
            end else if (hold_flag_i) begin
                {h_pc, h_ifid, h_idex} = 3'b111;
                state_d = EX_HOLD;
                left_d  = TC_LOAD;
            end else if (load_use_i) begin
                h_pc   = 1'b1;
                h_ifid = 1'b1;
                f_idex = 1'b1;
            end
        end
    end

    assign jump_en_o     = rst_n & jmp;
    assign jump_addr_o   = jump_en_o ? jump_addr_i : 32'h0;
    assign hold_pc_o     = rst_n & h_pc;
    assign hold_if_id_o  = rst_n & h_ifid;
    assign hold_id_ex_o  = rst_n & h_idex;
    assign flush_if_id_o = rst_n & f_ifid;
    assign flush_id_ex_o = rst_n & f_idex;
    assign state_o       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            left_q      <= '0;
            timeout_o   <= 1'b0;
            stall_cnt_o <= 32'h0;
            flush_cnt_o <= 32'h0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            if (to_set) timeout_o <= 1'b1;
            if (cnt_clr_i)
                stall_cnt_o <= 32'h0;
            else if (hold_pc_o && stall_cnt_o != 32'hFFFF_FFFF)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (cnt_clr_i)
                flush_cnt_o <= 32'h0;
            else if (jump_en_o && flush_cnt_o != 32'hFFFF_FFFF)
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0, hold_flag_i = 1'b0, load_use_i = 1'b0;
    logic        ext_hold_i = 1'b0, cnt_clr_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o;
    logic        timeout_o;
    logic [31:0] jump_addr_o, stall_cnt_o, flush_cnt_o;
    logic [1:0]  state_o;

    pipe_ctrl #(.TIMEOUT_CYCLES(8), .TO_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .load_use_i(load_use_i), .ext_hold_i(ext_hold_i),
        .cnt_clr_i(cnt_clr_i), .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
        .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o), .state_o(state_o),
        .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    // ctl bits: {jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_JMP  = 6'b100011;
    localparam logic [5:0] C_ALLH = 6'b011100;
    localparam logic [5:0] C_LU   = 6'b011001;
    localparam logic [5:0] C_TO   = 6'b000001;

    typedef struct {
        string       nm;
        logic [5:0]  ctl;
        logic [31:0] addr;
        logic [1:0]  st;
        logic        to;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;

    task automatic step(input string nm, input logic rst, input logic ext, input logic jmp,
                        input logic [31:0] addr, input logic hf, input logic lu, input logic clr,
                        input logic [5:0] ctl, input logic [1:0] st, input logic to,
                        input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        ext_hold_i  = ext;
        jump_en_i   = jmp;
        jump_addr_i = addr;
        hold_flag_i = hf;
        load_use_i  = lu;
        cnt_clr_i   = clr;
        rst_n       = rst;
        e.nm   = nm;
        e.ctl  = ctl;
        e.addr = ctl[5] ? addr : 32'h0;
        e.st   = st;
        e.to   = to;
        e.sc   = sc;
        e.fc   = fc;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [5:0] act_ctl;
            e = q.pop_front();
            act_ctl = {jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o};
            n_tests++;
            if (act_ctl !== e.ctl || jump_addr_o !== e.addr || state_o !== e.st ||
                timeout_o !== e.to || stall_cnt_o !== e.sc || flush_cnt_o !== e.fc) begin
                n_fail++;
                $display("FAIL %s: got ctl=%b addr=%h st=%0d to=%b sc=%0d fc=%0d, want ctl=%b addr=%h st=%0d to=%b sc=%0d fc=%0d",
                         e.nm, act_ctl, jump_addr_o, state_o, timeout_o, stall_cnt_o, flush_cnt_o,
                         e.ctl, e.addr, e.st, e.to, e.sc, e.fc);
            end
        end
    end

    initial begin
        //    name          rst ext jmp addr          hf lu clr  ctl     st to sc  fc
        step("reset",       0,  0,  1, 32'h0000_0050, 1, 1, 0,  C_NONE, 0, 0, 0,  0);
        step("idle",        1,  0,  0, 32'h0,         0, 0, 0,  C_NONE, 0, 0, 0,  0);
        step("t1_jump",     1,  0,  1, 32'h0000_0100, 0, 0, 0,  C_JMP,  0, 0, 0,  0);
        step("t1_after",    1,  0,  0, 32'h0,         0, 0, 0,  C_NONE, 0, 0, 0,  1);
        step("t2_lu",       1,  0,  0, 32'h0,         0, 1, 0,  C_LU,   0, 0, 0,  1);
        step("t2_after",    1,  0,  0, 32'h0,         0, 0, 0,  C_NONE, 0, 0, 1,  1);
        step("t3_hold1",    1,  0,  0, 32'h0,         1, 0, 0,  C_ALLH, 0, 0, 1,  1);
        for (int k = 2; k <= 5; k++)
            step("t3_holdn", 1, 0,  0, 32'h0,         1, 0, 0,  C_ALLH, 1, 0, 32'(k), 1);
        step("t3_release",  1,  0,  1, 32'h0000_0200, 0, 0, 0,  C_JMP,  1, 0, 6,  1);
        step("t3_after",    1,  0,  0, 32'h0,         0, 0, 0,  C_NONE, 0, 0, 6,  2);
        step("t4_hold1",    1,  0,  0, 32'h0,         1, 0, 0,  C_ALLH, 0, 0, 6,  2);
        for (int k = 2; k <= 7; k++)
            step("t4_holdn", 1, 0,  0, 32'h0,         1, 0, 0,  C_ALLH, 1, 0, 32'(5 + k), 2);
        step("t4_timeout",  1,  0,  0, 32'h0,         1, 0, 0,  C_TO,   1, 0, 13, 2);
        step("t4_sticky",   1,  0,  0, 32'h0,         0, 0, 0,  C_NONE, 0, 1, 13, 2);
        step("t4_sticky2",  1,  0,  0, 32'h0,         0, 1, 0,  C_LU,   0, 1, 13, 2);
        step("t5_ext1",     1,  1,  1, 32'h0000_0300, 0, 0, 0,  C_ALLH, 0, 1, 14, 2);
        step("t5_ext2",     1,  1,  1, 32'h0000_0300, 0, 0, 0,  C_ALLH, 2, 1, 15, 2);
        step("t5_ext3",     1,  1,  1, 32'h0000_0300, 0, 0, 0,  C_ALLH, 2, 1, 16, 2);
        step("t5_release",  1,  0,  1, 32'h0000_0300, 0, 0, 0,  C_JMP,  2, 1, 17, 2);
        step("t5_after",    1,  0,  0, 32'h0,         0, 0, 0,  C_NONE, 0, 1, 17, 3);
        step("jmp_over_lu", 1,  0,  1, 32'h0000_0400, 1, 1, 0,  C_JMP,  0, 1, 17, 3);
        step("exh_enter",   1,  0,  0, 32'h0,         1, 0, 0,  C_ALLH, 0, 1, 17, 4);
        step("exh_to_ext",  1,  1,  0, 32'h0,         1, 0, 0,  C_ALLH, 1, 1, 18, 4);
        step("ext_to_exh",  1,  0,  0, 32'h0,         1, 0, 0,  C_ALLH, 2, 1, 19, 4);
        step("exh_to_lu",   1,  0,  0, 32'h0,         0, 1, 0,  C_LU,   1, 1, 20, 4);
        step("t6_clr",      1,  0,  0, 32'h0,         0, 1, 1,  C_LU,   0, 1, 21, 4);
        step("t6_after",    1,  0,  0, 32'h0,         0, 0, 0,  C_NONE, 0, 1, 0,  0);
        step("rst_hold1",   1,  0,  0, 32'h0,         1, 0, 0,  C_ALLH, 0, 1, 0,  0);
        step("rst_hold2",   1,  0,  0, 32'h0,         1, 0, 0,  C_ALLH, 1, 1, 1,  0);
        step("rst_mid",     0,  0,  0, 32'h0,         1, 0, 0,  C_NONE, 0, 0, 0,  0);
        step("rst_after",   1,  0,  0, 32'h0,         0, 0, 0,  C_NONE, 0, 0, 0,  0);
        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control/hazard scheduler for the 3-stage core (pc_reg → if_id → id_ex → ex).
- Takes redirect and hold requests from ex, load-use hazard from id, and an external stall (bus/debug).
- Produces per-stage hold/flush plus the PC redirect, with multi-cycle hold tracking, a stuck-hold timeout and stall/flush performance counters.

Parameters:
TIMEOUT_CYCLES, 1024, max consecutive EX_HOLD cycles before forced release; legal range 2..2^TO_W.
TO_W, 10, width of the EX_HOLD cycle counter.

Ports:
clk  in  1  system clock
rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
jump_en_i  in  1  redirect request from ex
jump_addr_i  in  32  redirect target from ex
hold_flag_i  in  1  ex multi-cycle hold request (level)
load_use_i  in  1  id load-use hazard (level)
ext_hold_i  in  1  external stall request (level)
cnt_clr_i  in  1  synchronous clear of the perf counters
jump_en_o  out  1  PC redirect enable to pc_reg
jump_addr_o  out  32  PC redirect target
hold_pc_o  out  1  freeze PC
hold_if_id_o  out  1  freeze if_id register
hold_id_ex_o  out  1  freeze id_ex register
flush_if_id_o  out  1  load NOP into if_id
flush_id_ex_o  out  1  load NOP into id_ex
state_o  out  2  FSM state: RUN=0, EX_HOLD=1, EXT_HOLD=2
timeout_o  out  1  sticky stuck-hold error
stall_cnt_o  out  32  cycles with hold_pc_o=1
flush_cnt_o  out  32  cycles with jump_en_o=1

Behaviour:
- Control outputs are combinational from state, inputs and the counter; all state, counters and timeout_o are registered on the clk rising edge.
- While rst_n=0: all hold, flush and jump outputs are 0; jump_addr_o=0; state RUN; counters 0; timeout_o 0.
- jump_addr_o = jump_addr_i when jump_en_o=1, else 0.
- RUN rules, first match wins:
  - ext_hold_i=1 → all three holds=1, no flush, no jump; next EXT_HOLD.
  - jump_en_i=1 → jump_en_o=1, both flushes=1, holds=0; next RUN. Jump wins over hold_flag_i and load_use_i.
  - hold_flag_i=1 → all three holds=1; next EX_HOLD; hold counter loads 1.
  - load_use_i=1 → hold_pc=1, hold_if_id=1, flush_id_ex=1 (bubble), hold_id_ex=0; next RUN.
  - otherwise all outputs 0.
- EX_HOLD:
  - ext_hold_i=1 → all holds=1; next EXT_HOLD; counter cleared.
  - hold_flag_i=1 and counter < TIMEOUT_CYCLES-1 → all holds=1; counter +1; stay.
  - hold_flag_i=1 and counter = TIMEOUT_CYCLES-1 → holds=0, flush_id_ex=1 (kills the stuck instruction); timeout_o set at the next edge; next RUN; counter 0.
  - hold_flag_i=0 → apply RUN rules in this same cycle (zero-latency release, so an ex result jump takes effect immediately); next state per RUN; counter 0.
- EXT_HOLD:
  - ext_hold_i=1 → all holds=1; jump_en_i is ignored (the instruction stays held in ex and re-asserts after release).
  - ext_hold_i=0 → apply RUN rules in this same cycle.
- timeout_o stays set until reset; it does not block normal operation.
- Perf counters:
  - stall_cnt_o increments when hold_pc_o=1; flush_cnt_o increments when jump_en_o=1.
  - Both saturate at 32'hFFFF_FFFF.
  - cnt_clr_i=1 forces 0 and wins over a same-cycle increment.
- Illegal or unused state encoding 3 → next RUN; outputs follow the RUN rules.
- Reset asserted mid-hold immediately drops all holds and returns the FSM to RUN.

Test Plan:
1. RUN, jump_en_i=1, jump_addr_i=0x0000_0100 for 1 cycle → same cycle: jump_en_o=1, jump_addr_o=0x100, flush_if_id=flush_id_ex=1, holds 0; flush_cnt_o=1 after the edge.
2. load_use_i=1 for 1 cycle → hold_pc=1, hold_if_id=1, flush_id_ex=1, hold_id_ex=0; stall_cnt_o=1; state stays 0.
3. hold_flag_i=1 for 5 cycles, then 0 with jump_en_i=1, addr 0x200 → 5 cycles all holds=1 (state_o=1 from cycle 2), release cycle jump_en_o=1 with both flushes; stall_cnt_o=5, state_o=0.
4. TIMEOUT_CYCLES=8, hold_flag_i stuck at 1 → holds=1 for 7 cycles; 8th cycle holds=0, flush_id_ex=1; timeout_o=1 from the next edge and remains 1 after hold_flag_i drops.
5. ext_hold_i=1 and jump_en_i=1 together for 3 cycles → jump_en_o=0, holds=1, state_o=2; release cycle with jump_en_i=1 → jump_en_o=1, flushes=1.
6. Reset mid-EX_HOLD: rst_n low at cycle 3 → all outputs 0 immediately, state_o=0, counters 0. Separately, cnt_clr_i=1 during a stall cycle → stall_cnt_o=0 after the edge.
